// File: rtl/paint_draw_if.sv
// paint_draw_if: operator inputs and VGA pixel outputs of the paint draw controller
interface paint_draw_if #(parameter int X_W = 8, parameter int Y_W = 7, parameter int C_W = 3);
   logic           go;
   logic [1:0]     mode;
   logic [X_W-1:0] data_in;
   logic [C_W-1:0] colour_in;
   logic [X_W-1:0] x_out;
   logic [Y_W-1:0] y_out;
   logic [C_W-1:0] colour_out;
   logic           plot;
   logic           busy;
   logic           done;
   modport master (output go, mode, data_in, colour_in,
                   input  x_out, y_out, colour_out, plot, busy, done);
   modport slave  (input  go, mode, data_in, colour_in,
                   output x_out, y_out, colour_out, plot, busy, done);
endinterface

// File: rtl/paint_draw_fsm.sv
// paint_draw_fsm: loads corner coordinates on key presses and raster-scans a pixel,
// rectangle outline or filled rectangle into a VGA adapter.
module paint_draw_fsm #(
   parameter int X_W = 8,
   parameter int Y_W = 7,
   parameter int C_W = 3
) (
   input logic         Clock,
   input logic         reset_N,
   paint_draw_if.slave bus
);
   localparam logic [2:0] S_WAIT   = 3'd0;
   localparam logic [2:0] S_GOT_X  = 3'd1;
   localparam logic [2:0] S_GOT_Y  = 3'd2;
   localparam logic [2:0] S_GOT_X2 = 3'd3;
   localparam logic [2:0] S_DRAW   = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;
   logic [2:0]     state, nxt;
   logic           go_q, go_edge, abort, last, adv, enter;
   logic [1:0]     mode_r;
   logic [C_W-1:0] colour;
   logic [X_W-1:0] x1, x2, cx, xmin, xmax, xb_n, xmin_n, xmax_n;
   logic [Y_W-1:0] y1, y2, cy, ymin, ymax, y_new, ya_n, ymin_n, ymax_n;
   assign go_edge = bus.go & ~go_q;
   assign abort   = (state != S_WAIT) && (bus.mode == 2'b00);
   assign adv     = go_edge && !abort;
   assign last    = (cx == xmax) && (cy == ymax);
   assign y_new   = bus.data_in[Y_W-1:0];
   // a pixel shape enters DRAW from GOT_X, so both corners collapse onto X1/Y1
   assign xb_n    = (state == S_GOT_X) ? x1 : x2;
   assign ya_n    = (state == S_GOT_X) ? y_new : y1;
   assign xmin_n  = (x1 < xb_n) ? x1 : xb_n;
   assign xmax_n  = (x1 < xb_n) ? xb_n : x1;
   assign ymin_n  = (ya_n < y_new) ? ya_n : y_new;
   assign ymax_n  = (ya_n < y_new) ? y_new : ya_n;
   assign enter   = (nxt == S_DRAW) && (state != S_DRAW);
   always_comb begin
      nxt = state;
      case (state)
         S_WAIT:   nxt = (go_edge && bus.mode != 2'b00) ? S_GOT_X : S_WAIT;
         S_GOT_X:  nxt = adv ? ((mode_r == 2'b01) ? S_DRAW : S_GOT_Y) : S_GOT_X;
         S_GOT_Y:  nxt = adv ? S_GOT_X2 : S_GOT_Y;
         S_GOT_X2: nxt = adv ? S_DRAW : S_GOT_X2;
         S_DRAW:   nxt = last ? S_DONE : S_DRAW;
         S_DONE:   nxt = S_WAIT;
         default:  nxt = S_WAIT;
      endcase
      if (abort) nxt = S_WAIT;
   end
   always_ff @(posedge Clock or negedge reset_N) begin
      if (!reset_N) begin
         state  <= S_WAIT;
         go_q   <= 1'b0;
         mode_r <= 2'b00;
         colour <= '0;
         x1     <= '0;
         x2     <= '0;
         y1     <= '0;
         y2     <= '0;
         cx     <= '0;
         cy     <= '0;
         xmin   <= '0;
         xmax   <= '0;
         ymin   <= '0;
         ymax   <= '0;
      end else begin
         go_q  <= bus.go;
         state <= nxt;
         if (state == S_WAIT && nxt == S_GOT_X) begin
            x1     <= bus.data_in;
            colour <= bus.colour_in;
            mode_r <= bus.mode;
         end
         if (state == S_GOT_X && adv) y1 <= y_new;
         if (state == S_GOT_Y && adv) x2 <= bus.data_in;
         if (state == S_GOT_X2 && adv) y2 <= y_new;
         // counters hold on the final pixel so the far corner never wraps
         if (enter) begin
            xmin <= xmin_n;
            xmax <= xmax_n;
            ymin <= ymin_n;
            ymax <= ymax_n;
            cx   <= xmin_n;
            cy   <= ymin_n;
         end else if (state == S_DRAW && !abort && !last) begin
            cx <= (cx == xmax) ? xmin : cx + 1'b1;
            cy <= (cx == xmax) ? cy + 1'b1 : cy;
         end
      end
   end
   assign bus.x_out      = cx;
   assign bus.y_out      = cy;
   assign bus.colour_out = colour;
   assign bus.busy       = state != S_WAIT;
   assign bus.done       = (state == S_DONE) && !abort;
   assign bus.plot       = (state == S_DRAW) && !abort &&
                           (mode_r != 2'b10 || cx == xmin || cx == xmax || cy == ymin || cy == ymax);
endmodule

// File: doc/paint_draw_fsm.md
PAINT_DRAW_FSM -- requirements
Module: paint_draw_fsm

Interface
REQ-001 Parameter X_W, default 8, SHALL set the X coordinate width (160-column VGA).
REQ-002 Parameter Y_W, default 7, SHALL set the Y coordinate width (120-row VGA).
REQ-003 Parameter C_W, default 3, SHALL set the colour width.
REQ-004 Clock  in  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-005 reset_N  in  1  SHALL be the reset: asynchronous, active-low.
REQ-006 go  in  1  SHALL be the level input from the operator key; only its rising edge (go_edge) acts.
REQ-007 mode  in  2  SHALL select the drawing mode: 00 none, 01 single pixel, 10 rectangle outline, 11 filled rectangle.
REQ-008 data_in  in  X_W  SHALL carry the coordinate being loaded; Y loads use bits [Y_W-1:0].
REQ-009 colour_in  in  C_W  SHALL carry the pixel colour.
REQ-010 x_out  out  X_W  SHALL carry the pixel X address to the VGA adapter.
REQ-011 y_out  out  Y_W  SHALL carry the pixel Y address.
REQ-012 colour_out  out  C_W  SHALL carry the latched colour.
REQ-013 plot  out  1  SHALL act as the write enable to the VGA adapter.
REQ-014 busy  out  1  SHALL be 1 in every state except WAIT.
REQ-015 done  out  1  SHALL pulse high for exactly one cycle when a shape completes.

Function
REQ-016 go_edge SHALL equal go AND NOT go_q, where go_q is go registered on Clock.
REQ-017 States SHALL be WAIT, GOT_X, GOT_Y, GOT_X2, DRAW and DONE.
REQ-018 WAIT: on go_edge with mode != 00, the block SHALL latch X1 = data_in, colour = colour_in and mode_r = mode, then enter GOT_X; go_edge with mode = 00 SHALL be ignored.
REQ-019 GOT_X: on go_edge, the block SHALL latch Y1 = data_in[Y_W-1:0]; next state SHALL be DRAW if mode_r = 01, otherwise GOT_Y.
REQ-020 GOT_Y: on go_edge, the block SHALL latch X2, then enter GOT_X2.
REQ-021 GOT_X2: on go_edge, the block SHALL latch Y2, then enter DRAW.
REQ-022 On every entry to DRAW, the block SHALL compute xmin/xmax = min/max(X1,X2) and ymin/ymax = min/max(Y1,Y2), and set counters cx = xmin and cy = ymin; corner order SHALL not matter.
REQ-023 In mode 01, xmin = xmax = X1 and ymin = ymax = Y1, so DRAW SHALL last exactly 1 cycle.
REQ-024 DRAW SHALL scan in raster order, cx inner: if cx == xmax then cx <= xmin and cy <= cy+1, else cx <= cx+1; at cx == xmax and cy == ymax the next state SHALL be DONE.
REQ-025 DRAW duration SHALL be exactly W*H cycles, with W = xmax-xmin+1 and H = ymax-ymin+1, in every mode.
REQ-026 The end-of-scan comparison SHALL occur before increment, so xmax = 2^X_W-1 and ymax = 2^Y_W-1 complete without counter wrap.
REQ-027 x_out SHALL equal cx, y_out SHALL equal cy, and colour_out SHALL equal the latched colour at all times.
REQ-028 plot SHALL be 1 only in DRAW, and only when the pixel is on the shape: modes 01/11 every DRAW cycle; mode 10 only when cx == xmin, cx == xmax, cy == ymin or cy == ymax.
REQ-029 DONE SHALL assert done = 1 and plot = 0 for one cycle, then return to WAIT.
REQ-030 go_edge SHALL be ignored in DRAW and DONE.
REQ-031 Abort: mode == 00 in any state other than WAIT SHALL force the next state to WAIT, with plot = 0 that cycle and no done pulse.
REQ-032 An abort in the same cycle as go_edge SHALL take priority; no register is latched.
REQ-033 Changes to the mode input other than 00 after WAIT SHALL be ignored, since mode_r governs the operation.

Reset
REQ-034 reset_N = 0 SHALL immediately force state WAIT and zero go_q, X1, Y1, X2, Y2, cx, cy, colour, mode_r, x_out, y_out, colour_out, plot, busy and done, independent of Clock.
REQ-035 A reset asserted mid-DRAW SHALL end the drawing with no further plot and no done pulse.
REQ-036 After reset_N deasserts, the first go_edge SHALL be judged against go_q = 0, so a key already held at release counts as one edge.

Verification
REQ-037 Pixel: mode=01, X1=5, Y1=7, colour=3'b100 -> exactly one plot cycle at (5,7) colour 100, then done for 1 cycle, then busy=0.
REQ-038 Filled, swapped corners: mode=11, (X1,Y1)=(12,9), (X2,Y2)=(10,8) -> 6 plot cycles in order (10,8),(11,8),(12,8),(10,9),(11,9),(12,9), then done.
REQ-039 Outline 4x3: mode=10, corners (0,0) and (3,2) -> 12 DRAW cycles with plot=1 on 10 of them; plot=0 at (1,1) and (2,1).
REQ-040 Edge case: corners (159,119) and (255,127) in mode 11 -> scan ends at (255,127) with no wrap, and DRAW lasts 97*9 = 873 cycles.
REQ-041 Abort and reset: mode forced to 00 in GOT_Y -> WAIT next cycle with no done; reset_N pulsed low mid-DRAW -> plot=0 immediately and all outputs zero.
REQ-042 Handshake: go held high for 50 cycles counts as one load; go_edge during DRAW leaves the pixel count unchanged.
